// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and opcode type for the execute-stage ALU.
// Flag logic in the top is enabled by defining ALU_FLAGS_EN.
package alu_pkg;

  localparam int WORDSIZE  = 32;
  localparam int IMMSIZE   = 20;
  localparam int OPSIZE    = 4;
  localparam int SIU_SHIFT = WORDSIZE - IMMSIZE;

  typedef logic [OPSIZE-1:0] opcode_t;

  localparam opcode_t NOP = 4'd0;
  localparam opcode_t ADD = 4'd1;
  localparam opcode_t SUB = 4'd2;
  localparam opcode_t SLL = 4'd3;
  localparam opcode_t SRL = 4'd4;
  localparam opcode_t SRA = 4'd5;
  localparam opcode_t SLU = 4'd6;
  localparam opcode_t SLT = 4'd7;
  localparam opcode_t OR  = 4'd8;
  localparam opcode_t AND = 4'd9;
  localparam opcode_t XOR = 4'd10;
  localparam opcode_t SIU = 4'd11;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA and the fixed upper-immediate shift.
// Non-shift opcodes produce zero; the top selects this result only for shift ops.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WORDSIZE-1:0] a,
  input  logic [4:0]          shamt,
  input  opcode_t             op,
  output logic [WORDSIZE-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      SLL:     result = a << shamt;
      SRL:     result = a >> shamt;
      SRA:     result = $signed(a) >>> shamt;
      SIU:     result = a << SIU_SHIFT;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Single-stage registered 32-bit ALU with optional C/V/Z/N flags.
// Define ALU_FLAGS_EN to build the flag logic; otherwise the flags are tied low.
module alu
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WORDSIZE-1:0] A,
  input  logic [WORDSIZE-1:0] B,
  input  opcode_t             OP,
  output logic [WORDSIZE-1:0] OUT,
  output logic                C,
  output logic                V,
  output logic                Z,
  output logic                N
);

  logic [WORDSIZE-1:0] add_sum;
  logic [WORDSIZE-1:0] sub_diff;
  logic [WORDSIZE-1:0] shift_res;
  logic [WORDSIZE-1:0] res;

  assign add_sum  = A + B;
  assign sub_diff = A - B;

  alu_shifter u_shifter (
    .a      (A),
    .shamt  (B[4:0]),
    .op     (OP),
    .result (shift_res)
  );

  always_comb begin
    res = '0;
    case (OP)
      ADD:                res = add_sum;
      SUB:                res = sub_diff;
      SLL, SRL, SRA, SIU: res = shift_res;
      SLU:                res = WORDSIZE'(A < B);
      SLT:                res = WORDSIZE'($signed(A) < $signed(B));
      OR:                 res = A | B;
      AND:                res = A & B;
      XOR:                res = A ^ B;
      default:            res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) OUT <= '0;
    else     OUT <= res;
  end

`ifdef ALU_FLAGS_EN
  logic a_msb, b_msb;
  logic carry_next, ovf_next;
  logic c_q, v_q, z_q, n_q;

  assign a_msb = A[WORDSIZE-1];
  assign b_msb = B[WORDSIZE-1];

  // Carry out of bit 31 recovered from operand and result MSBs; SUB adds ~B + 1.
  always_comb begin
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (OP)
      ADD: begin
        carry_next = (a_msb & b_msb) | ((a_msb | b_msb) & ~add_sum[WORDSIZE-1]);
        ovf_next   = (a_msb == b_msb) && (add_sum[WORDSIZE-1] != a_msb);
      end
      SUB: begin
        carry_next = (a_msb & ~b_msb) | ((a_msb | ~b_msb) & ~sub_diff[WORDSIZE-1]);
        ovf_next   = (a_msb != b_msb) && (sub_diff[WORDSIZE-1] != a_msb);
      end
      default: begin
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b1;
      n_q <= 1'b0;
    end else begin
      c_q <= carry_next;
      v_q <= ovf_next;
      z_q <= (res == '0);
      n_q <= res[WORDSIZE-1];
    end
  end

  assign C = c_q;
  assign V = v_q;
  assign Z = z_q;
  assign N = n_q;
`else
  assign C = 1'b0;
  assign V = 1'b0;
  assign Z = 1'b0;
  assign N = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; flag expectations follow ALU_FLAGS_EN.
module tb_alu;
  import alu_pkg::*;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct {
    opcode_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  opcode_t     OP;
  logic [31:0] OUT;
  logic        C, V, Z, N;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  alu dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .OP  (OP),
    .OUT (OUT),
    .C   (C),
    .V   (V),
    .Z   (Z),
    .N   (N)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] eout,
                           input logic ec, input logic ev, input logic ez, input logic en);
    check({name, " OUT"}, OUT, eout);
    check({name, " C"}, 32'(C), 32'(ec & FLAGS_ON));
    check({name, " V"}, 32'(V), 32'(ev & FLAGS_ON));
    check({name, " Z"}, 32'(Z), 32'(ez & FLAGS_ON));
    check({name, " N"}, 32'(N), 32'(en & FLAGS_ON));
  endtask

  task automatic drive(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    OP = op;
    A  = a;
    B  = b;
  endtask

  initial begin
    //                op   a             b             out           c     v     z     n
    vecs.push_back('{ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, "add_carry"});
    vecs.push_back('{ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf"});
    vecs.push_back('{ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, "add_small"});
    vecs.push_back('{SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow"});
    vecs.push_back('{SUB, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero"});
    vecs.push_back('{SUB, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, "sub_5_3"});
    vecs.push_back('{SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf"});
    vecs.push_back('{SLL, 32'h80000000, 32'h00000023, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "sll"});
    vecs.push_back('{SRL, 32'h80000000, 32'h00000023, 32'h10000000, 1'b0, 1'b0, 1'b0, 1'b0, "srl"});
    vecs.push_back('{SRA, 32'h80000000, 32'h00000023, 32'hF0000000, 1'b0, 1'b0, 1'b0, 1'b1, "sra"});
    vecs.push_back('{SLL, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1, "sll_31"});
    vecs.push_back('{SRA, 32'h40000000, 32'h0000001E, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "sra_pos"});
    vecs.push_back('{SIU, 32'h000ABCDE, 32'h12345678, 32'hABCDE000, 1'b0, 1'b0, 1'b0, 1'b1, "siu"});
    vecs.push_back('{SLU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "slu_big"});
    vecs.push_back('{SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "slt_neg"});
    vecs.push_back('{SLU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, "slu_small"});
    vecs.push_back('{SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "slt_pos"});
    vecs.push_back('{OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1, "or"});
    vecs.push_back('{AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1, "and"});
    vecs.push_back('{XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0, "xor"});
    vecs.push_back('{NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "nop"});
    vecs.push_back('{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "op12"});
    vecs.push_back('{4'd15, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, "op15"});

    // Reset with a live ADD on the inputs: reset must win.
    rst = 1'b1;
    drive(ADD, 32'h00000001, 32'h00000002);
    @(posedge clk); #1;
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back vectors, one op per cycle, result one edge after inputs.
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check_all(vecs[i].name, vecs[i].out, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
    end

    // Mid-cycle input change must not disturb the registered result.
    drive(ADD, 32'h00000010, 32'h00000020);
    @(posedge clk); #1;
    check_all("hold_pre", 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(SUB, 32'h00000000, 32'h00000001);
    #3;
    check_all("hold_mid", 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("hold_post", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-stream reset, then first valid result on the edge after deassertion.
    rst = 1'b1;
    drive(ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check_all("reset_mid", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("after_reset", 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
